sig_sync_filt: RTL and testbench

Multi-channel, parametrised clock-domain-crossing input conditioner and the next generation of the team's two-flop synchroniser. Each channel passes through a configurable-depth synchroniser chain, then a consecutive-sample glitch filter, then a registered edge detector. It sits directly behind asynchronous pins such as UART RX, buttons and external strobes, and feeds clean levels plus single-cycle rise/fall pulses to the consuming FSMs in the `clk` domain.

---
 rtl/sig_sync_filt.sv | 102 ++++++++++
 tb/tb_sig_sync_filt.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sig_sync_filt.sv
// sig_sync_filt: multi-channel input conditioner for asynchronous pins.
// Each channel runs through a STAGES-deep synchroniser chain, a glitch
// filter that requires FILT_CNT consecutive differing samples before the
// filtered level follows, and a registered edge detector producing
// single-cycle rise/fall pulses aligned with the new filtered level.
//
// Streaming contract: there is no valid/ready handshake. Every channel
// accepts one sample per clock and every output is meaningful on every
// cycle outside reset; there is no stall and no back-pressure.
module sig_sync_filt #(
    parameter int               WIDTH    = 4,
    parameter int               STAGES   = 2,
    parameter int               FILT_CNT = 4,
    parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sig_async,
    output logic [WIDTH-1:0] sig_sync,
    output logic [WIDTH-1:0] sig_filt,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Counter must hold 0..FILT_CNT-1; keep at least one bit.
    localparam int CNT_W = (FILT_CNT < 2) ? 1 : $clog2(FILT_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CNT - 1);

    // Reject configurations that cannot work.
    if (STAGES < 2) begin : g_bad_stages
        $error("sig_sync_filt: STAGES must be at least 2");
    end
    if (FILT_CNT < 1) begin : g_bad_filt
        $error("sig_sync_filt: FILT_CNT must be at least 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sig_sync_filt: WIDTH must be at least 1");
    end

    // Synchroniser chain, all channels side by side. Index 0 captures the
    // raw pin; nothing but wires sits between successive stages.
    logic [WIDTH-1:0] sync_chain [STAGES];

    // Shift the raw inputs through the chain; reset loads the idle levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_chain[k] <= RST_VAL;
            end
        end else begin
            sync_chain[0] <= sig_async;
            for (int k = 1; k < STAGES; k++) begin
                sync_chain[k] <= sync_chain[k-1];
            end
        end
    end

    assign sig_sync = sync_chain[STAGES-1];

    // Per-channel glitch filter and edge detector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic             filt;
        logic             rise_q;
        logic             fall_q;
        logic             differ;
        logic             update;

        // The synchronised level disagrees with the accepted level.
        assign differ = sig_sync[i] ^ filt;
        // This is the FILT_CNT-th consecutive disagreeing sample.
        assign update = differ & (cnt == CNT_MAX);

        // Count consecutive disagreeing samples; any agreeing sample clears
        // the count so separate glitches never add up. The edge pulses are
        // registered alongside filt so they coincide with the new level.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                filt   <= RST_VAL[i];
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= update & sig_sync[i];
                fall_q <= update & ~sig_sync[i];
                if (!differ) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    filt <= sig_sync[i];
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign sig_filt[i] = filt;
        assign rise[i]     = rise_q;
        assign fall[i]     = fall_q;
    end

endmodule

// File: tb/tb_sig_sync_filt.sv
// Testbench for sig_sync_filt (WIDTH=4, STAGES=2, FILT_CNT=4, RST_VAL=0001).
// A reference model, driven from the stimulus the bench itself applies,
// pushes the expected outputs for every clock edge into exp_q; a monitor
// pops one entry per edge and compares it against the DUT outputs.
module tb_sig_sync_filt;

    localparam int           W   = 4;
    localparam int           STG = 2;
    localparam int           FC  = 4;
    localparam logic [W-1:0] RV  = 4'b0001;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sig_async;
    logic [W-1:0] sig_sync;
    logic [W-1:0] sig_filt;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    always #5 clk = ~clk;

    sig_sync_filt #(
        .WIDTH    (W),
        .STAGES   (STG),
        .FILT_CNT (FC),
        .RST_VAL  (RV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_async (sig_async),
        .sig_sync  (sig_sync),
        .sig_filt  (sig_filt),
        .rise      (rise),
        .fall      (fall)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [W-1:0] sync;
        logic [W-1:0] filt;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // pipe: delay line of the raw samples, oldest first; its head is the
    // level visible on sig_sync. sync_log: the sig_sync level seen at each
    // clock edge. A channel's filtered level flips once the last FC logged
    // levels since its previous flip (or reset) all differ from it.
    logic [W-1:0] pipe[$];
    logic [W-1:0] sync_log[$];
    logic [W-1:0] m_filt;
    int           last_chg [W];

    task automatic model_reset();
        pipe = {};
        repeat (STG) pipe.push_back(RV);
        m_filt = RV;
        for (int i = 0; i < W; i++) last_chg[i] = sync_log.size();
    endtask

    task automatic model_step();
        exp_t         e;
        logic [W-1:0] old_sync;
        logic [W-1:0] v;
        logic [W-1:0] r;
        logic [W-1:0] f;
        int           idx;
        bit           all_diff;
        r = '0;
        f = '0;
        if (!rst_n) begin
            model_reset();
            e.sync = RV;
            e.filt = RV;
            e.rise = '0;
            e.fall = '0;
        end else begin
            old_sync = pipe[0];
            sync_log.push_back(old_sync);
            idx = sync_log.size() - 1;
            for (int i = 0; i < W; i++) begin
                if (idx - last_chg[i] + 1 >= FC) begin
                    all_diff = 1'b1;
                    for (int k = idx - FC + 1; k <= idx; k++) begin
                        v = sync_log[k];
                        if (v[i] == m_filt[i]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        if (old_sync[i]) r[i] = 1'b1;
                        else             f[i] = 1'b1;
                        m_filt[i]   = old_sync[i];
                        last_chg[i] = idx + 1;
                    end
                end
            end
            pipe.push_back(sig_async);
            void'(pipe.pop_front());
            e.sync = pipe[0];
            e.filt = m_filt;
            e.rise = r;
            e.fall = f;
        end
        exp_q.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sig_sync", sig_sync, e.sync);
                check("sig_filt", sig_filt, e.filt);
                check("rise", rise, e.rise);
                check("fall", fall, e.fall);
                check("rise_and_fall", rise & fall, '0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Both tasks start and end on a falling edge.
    task automatic drive(input logic [W-1:0] v, input int n);
        sig_async = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        #1;
        check("rst_sync_now", sig_sync, RV);
        check("rst_filt_now", sig_filt, RV);
        check("rst_rise_now", rise, '0);
        check("rst_fall_now", fall, '0);
        #1;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] v;
        int           div;
        rst_n     = 1'b1;
        sig_async = RV;
        #2;
        apply_reset(3);
        drive(RV, 4);

        // clean rise on channel 1, then back down
        drive(4'b0011, 10);
        drive(4'b0001, 10);

        // single 3-cycle glitch on channel 2, then 3 high / 1 low bursts
        drive(4'b0101, 3);
        drive(4'b0001, 8);
        for (int g = 0; g < 5; g++) begin
            drive(4'b0101, 3);
            drive(4'b0001, 1);
        end
        drive(4'b0001, 8);

        // exactly FILT_CNT cycles high on channel 3
        drive(4'b1001, 4);
        drive(4'b0001, 10);

        // channel 0 falls and channel 1 rises together
        drive(4'b0010, 10);
        drive(4'b0001, 10);

        // reset while channel 1 is two samples into its count
        drive(4'b0011, 4);
        apply_reset(2);
        drive(4'b0011, 10);
        drive(4'b0001, 10);

        // randomized traffic with varying toggle density and rare resets
        v   = RV;
        div = 4;
        for (int c = 0; c < 800; c++) begin
            if (c % 50 == 0) div = $urandom_range(1, 4) * 2;
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, div - 1) == 0) v[i] = ~v[i];
            end
            if ($urandom_range(0, 199) == 0) apply_reset($urandom_range(1, 3));
            drive(v, 1);
        end
        drive(RV, 10);

        // every expectation must have been consumed
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
